// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_pkg
// Purpose  : Shared definitions for the 1-to-N stream demultiplexer.
//            - state_t    : demux FSM state encoding
//            - DROP_CNT_W : width of the optional dropped-packet counter
//            - sel_in_range() : zero-extended range check of a select code
// Revision : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;

    // Both operands are widened to 32-bit unsigned so that a narrow select
    // is compared by value against the channel count, never sign-extended.
    function automatic logic sel_in_range(input logic [31:0] sel_ext,
                                          input int unsigned num_ch);
        return sel_ext < num_ch;
    endfunction

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/stream_demux_1_to_n_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pipe_reg
// Purpose  : One-deep valid/ready holding register for the demux egress
//            payload. A load takes priority over a drain in the same cycle,
//            which lets the register stream one beat per cycle.
// Ports    : clock, reset      - clock / synchronous active-high reset
//            load              - capture load_data/load_last, set valid
//            load_data/last    - beat to capture
//            drain             - current beat accepted downstream
//            valid/data/last   - registered beat
// Revision : 1.0 - initial release
// ============================================================================
module stream_pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              drain,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    always_ff @(posedge clock) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            // The controller only loads when the register is empty or is
            // being drained this cycle, so no beat is ever overwritten.
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule : stream_pipe_reg
`default_nettype wire

// File: rtl/stream_demux_1_to_n.sv
`default_nettype none
// ============================================================================
// Module   : stream_demux_1_to_n
// Purpose  : Registered 1-to-N packet demultiplexer with valid/ready
//            handshakes. The channel select is captured on the first beat of
//            a packet and held until its last beat; packets with an
//            out-of-range or unknown select are dropped whole and flagged.
// Ports    : clock, reset  - clock / synchronous active-high reset
//            sel           - destination channel (first beat only)
//            in_data/in_valid/in_last/in_ready - ingress stream
//            out_data/out_last - shared egress payload
//            out_valid[N]/out_ready[N] - per-channel handshake
//            err_sel       - one-cycle pulse per dropped packet
//            busy          - packet in progress or beat held
//            drop_cnt      - saturating dropped-packet count (optional)
// Config   : `define STREAM_DEMUX_DROP_CNT_EN adds the drop_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demux_1_to_n
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0] out_valid,
    output logic              out_last,
    input  logic [NUM_CH-1:0] out_ready,
    output logic              err_sel,
    output logic              busy
`ifdef STREAM_DEMUX_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [SEL_W-1:0]  ch_reg;
    logic              ch_load;
    logic              load;
    logic              err_nxt;
    logic              sel_ok;
    logic              valid_any;
    logic              out_ready_sel;
    logic              in_accept;
    logic              out_accept;

    // ------------------------------------------------------------------
    // Select qualification. An unknown select in simulation is treated
    // like an illegal code so it can never steer a beat anywhere.
    // ------------------------------------------------------------------
    assign sel_ok = !$isunknown(sel) &&
                    sel_in_range(32'(sel), NUM_CH);

    // Ready of the channel the held beat belongs to. A loop compare keeps
    // the index in range even when 2**SEL_W > NUM_CH.
    always_comb begin
        out_ready_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_reg == SEL_W'(i)) begin
                out_ready_sel = out_ready[i];
            end
        end
    end

    assign out_accept = valid_any & out_ready_sel;
    assign in_ready   = (state == ST_DROP) ? 1'b1 : (!valid_any | out_ready_sel);
    assign in_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            ch_reg  <= '0;
            err_sel <= 1'b0;
        end else begin
            state   <= state_nxt;
            err_sel <= err_nxt;
            // Only updated on ingress accept, when the holding register is
            // empty or draining, so the old beat finishes on its own channel.
            if (ch_load) begin
                ch_reg <= sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state, load enable and error pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ch_load   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_accept) begin
                    if (sel_ok) begin
                        load    = 1'b1;
                        ch_load = 1'b1;
                        if (!in_last) begin
                            state_nxt = ST_PASS;
                        end
                    end else begin
                        err_nxt = 1'b1;
                        if (!in_last) begin
                            state_nxt = ST_DROP;
                        end
                    end
                end
            end
            ST_PASS: begin
                if (in_accept) begin
                    load = 1'b1;
                    if (in_last) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // Beats are swallowed; nothing reaches the output register.
                if (in_accept && in_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Egress holding register
    // ------------------------------------------------------------------
    stream_pipe_reg #(
        .DATA_W (DATA_W)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (in_data),
        .load_last (in_last),
        .drain     (out_accept),
        .valid     (valid_any),
        .data      (out_data),
        .last      (out_last)
    );

    // Fan the single valid out to the captured channel only.
    always_comb begin
        out_valid = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_reg == SEL_W'(i)) begin
                out_valid[i] = valid_any;
            end
        end
    end

    assign busy = (state != ST_IDLE) | valid_any;

    // ------------------------------------------------------------------
    // Optional saturating dropped-packet counter
    // ------------------------------------------------------------------
`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (err_sel && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule : stream_demux_1_to_n
`default_nettype wire

// File: tb/tb_stream_demux_1_to_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demux_1_to_n
// Purpose  : Self-checking bench for stream_demux_1_to_n. dut4 (4 channels)
//            covers routing, back-pressure, back-to-back packets and reset;
//            dut3 (3 channels) covers the illegal-select drop path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1_to_n;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic       clock;
    logic       reset;

    // dut4 stimulus / observation
    logic [1:0] sel;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_valid;
    logic       out_last;
    logic [3:0] out_ready;
    logic       err_sel;
    logic       busy;

    // dut3 stimulus / observation
    logic [1:0] d3_sel;
    logic [7:0] d3_in_data;
    logic       d3_in_valid;
    logic       d3_in_last;
    logic       d3_in_ready;
    logic [7:0] d3_out_data;
    logic [2:0] d3_out_valid;
    logic       d3_out_last;
    logic [2:0] d3_out_ready;
    logic       d3_err_sel;
    logic       d3_busy;

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic [7:0] drop_cnt;
    logic [7:0] d3_drop_cnt;
`endif

    int    vectors    = 0;
    int    miscompares = 0;
    beat_t sb[$];
    int    d3_err_cnt   = 0;
    int    d3_valid_seen = 0;

    stream_demux_1_to_n #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_sel   (err_sel),
        .busy      (busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    stream_demux_1_to_n #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .sel       (d3_sel),
        .in_data   (d3_in_data),
        .in_valid  (d3_in_valid),
        .in_last   (d3_in_last),
        .in_ready  (d3_in_ready),
        .out_data  (d3_out_data),
        .out_valid (d3_out_valid),
        .out_last  (d3_out_last),
        .out_ready (d3_out_ready),
        .err_sel   (d3_err_sel),
        .busy      (d3_busy)
`ifdef STREAM_DEMUX_DROP_CNT_EN
        ,
        .drop_cnt  (d3_drop_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Egress scoreboard for dut4: every accepted output beat must match the
    // oldest expected beat, and out_valid must never have two bits set.
    always @(negedge clock) begin
        if (out_valid !== 4'b0) begin
            chk("onehot0", {31'b0, $onehot0(out_valid)}, 32'd1);
        end
        if ((out_valid & out_ready) !== 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {24'b0, out_data}, 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                int    ch_obs;
                e = sb.pop_front();
                ch_obs = -1;
                for (int i = 0; i < 4; i++) begin
                    if (out_valid[i]) ch_obs = i;
                end
                chk("egress_ch",   ch_obs, e.ch);
                chk("egress_data", {24'b0, out_data}, {24'b0, e.data});
                chk("egress_last", {31'b0, out_last}, {31'b0, e.last});
            end
        end
    end

    always @(negedge clock) begin
        if (d3_err_sel === 1'b1) d3_err_cnt++;
        if (d3_out_valid !== 3'b0) d3_valid_seen++;
    end

    // Drive one beat on dut4 and hold it until accepted (bounded). The
    // expected egress beat is queued at the moment of acceptance.
    task automatic send_beat(input logic [1:0] s, input logic [7:0] d,
                             input logic l, input int ch, output int waited);
        bit done;
        sel = s; in_data = d; in_last = l; in_valid = 1'b1;
        waited = 0;
        done = 1'b0;
        for (int w = 0; w <= 50 && !done; w++) begin
            @(negedge clock);
            if (in_ready === 1'b1) begin
                sb.push_back('{ch, d, l});
                done = 1'b1;
            end else begin
                waited++;
            end
            @(posedge clock); #1;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        int w;
        reset = 1'b1;
        sel = '0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 4'hF;
        d3_sel = '0; d3_in_data = '0; d3_in_valid = 1'b0; d3_in_last = 1'b0; d3_out_ready = 3'h7;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // ---- Reset state ----
        @(negedge clock);
        chk("rst_out_valid", {28'b0, out_valid}, 32'd0);
        chk("rst_out_data",  {24'b0, out_data}, 32'd0);
        chk("rst_out_last",  {31'b0, out_last}, 32'd0);
        chk("rst_err_sel",   {31'b0, err_sel}, 32'd0);
        chk("rst_busy",      {31'b0, busy}, 32'd0);
        chk("rst_in_ready",  {31'b0, in_ready}, 32'd1);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("rst_drop_cnt",  {24'b0, d3_drop_cnt}, 32'd0);
`endif
        @(posedge clock); #1;

        // ---- 1: single-beat packets on every channel ----
        for (int s = 0; s < 4; s++) begin
            send_beat(2'(s), 8'h10 + 8'(s), 1'b1, s, w);
            chk("t1_no_wait", w, 0);
            @(negedge clock);
            chk("t1_out_valid", {28'b0, out_valid}, 32'd1 << s);
            chk("t1_out_data",  {24'b0, out_data}, 32'h10 + s);
            @(posedge clock); #1;
        end

        // ---- 2: 4-beat packet, sel changes after first beat ----
        send_beat(2'd2, 8'hA0, 1'b0, 2, w);
        send_beat(2'd1, 8'hA1, 1'b0, 2, w);
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("t2_busy_mid", {31'b0, busy}, 32'd1);
        @(posedge clock); #1;
        send_beat(2'd1, 8'hA2, 1'b0, 2, w);
        send_beat(2'd1, 8'hA3, 1'b1, 2, w);
        @(negedge clock);
        chk("t2_last_valid", {28'b0, out_valid}, 32'h4);
        chk("t2_last_flag",  {31'b0, out_last}, 32'd1);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t2_idle_busy", {31'b0, busy}, 32'd0);
        @(posedge clock); #1;

        // ---- 3: back-pressure on channel 1 ----
        send_beat(2'd1, 8'hB0, 1'b0, 1, w);
        out_ready = 4'b1101;
        sel = 2'd1; in_data = 8'hB1; in_last = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("t3_in_ready",  {31'b0, in_ready}, 32'd0);
            chk("t3_hold_data", {24'b0, out_data}, 32'hB0);
            chk("t3_hold_valid", {28'b0, out_valid}, 32'h2);
            @(posedge clock); #1;
        end
        out_ready = 4'hF;
        send_beat(2'd1, 8'hB1, 1'b0, 1, w);
        chk("t3_release", w, 0);
        send_beat(2'd1, 8'hB2, 1'b1, 1, w);
        repeat (2) @(posedge clock);
        #1;

        // ---- 4: illegal select on the 3-channel instance ----
        for (int b = 0; b < 3; b++) begin
            d3_sel = 2'd3; d3_in_data = 8'hC0 + 8'(b);
            d3_in_last = (b == 2); d3_in_valid = 1'b1;
            @(negedge clock);
            chk("t4_in_ready", {31'b0, d3_in_ready}, 32'd1);
            chk("t4_err_pulse", {31'b0, d3_err_sel}, (b == 1) ? 32'd1 : 32'd0);
            @(posedge clock); #1;
        end
        d3_in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("t4_err_count", d3_err_cnt, 1);
        chk("t4_no_valid",  d3_valid_seen, 0);
        chk("t4_busy",      {31'b0, d3_busy}, 32'd0);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        chk("t4_drop_cnt",  {24'b0, d3_drop_cnt}, 32'd1);
        chk("t4_dut4_cnt",  {24'b0, drop_cnt}, 32'd0);
`endif
        @(posedge clock); #1;

        // ---- 5: back-to-back packets, old beat drains first ----
        send_beat(2'd0, 8'hD0, 1'b0, 0, w);
        send_beat(2'd0, 8'hD1, 1'b1, 0, w);
        out_ready = 4'b1110;
        sel = 2'd3; in_data = 8'hE0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clock);
        chk("t5_stall_ready", {31'b0, in_ready}, 32'd0);
        chk("t5_stall_valid", {28'b0, out_valid}, 32'h1);
        chk("t5_stall_data",  {24'b0, out_data}, 32'hD1);
        @(posedge clock); #1;
        out_ready = 4'hF;
        send_beat(2'd3, 8'hE0, 1'b1, 3, w);
        @(negedge clock);
        chk("t5_new_valid", {28'b0, out_valid}, 32'h8);
        chk("t5_new_data",  {24'b0, out_data}, 32'hE0);
        @(posedge clock); #1;

        // ---- 6: reset in the middle of a packet ----
        send_beat(2'd2, 8'hF0, 1'b0, 2, w);
        sel = 2'd2; in_data = 8'hF1; in_last = 1'b0; in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        chk("t6_rst_valid", {28'b0, out_valid}, 32'd0);
        chk("t6_rst_data",  {24'b0, out_data}, 32'd0);
        chk("t6_rst_busy",  {31'b0, busy}, 32'd0);
        @(posedge clock); #1;
        send_beat(2'd1, 8'h55, 1'b1, 1, w);
        @(negedge clock);
        chk("t6_new_valid", {28'b0, out_valid}, 32'h2);
        chk("t6_new_data",  {24'b0, out_data}, 32'h55);
        @(posedge clock); #1;

        repeat (3) @(posedge clock);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_stream_demux_1_to_n
`default_nettype wire
